// File: rtl/program_loader.sv
// program_loader: boot sequencer that clears data memory, streams a
// program into instruction memory, then runs the CPU for a fixed window.
`timescale 1ns/1ps

module program_loader #(
    parameter int INSTR_MEM_SIZE = 64,
    parameter int DATA_MEM_SIZE  = 32,
    parameter int RUN_CYCLES     = 14,
    localparam int IA = $clog2(INSTR_MEM_SIZE),
    localparam int DA = $clog2(DATA_MEM_SIZE),
    localparam int CW = $clog2(RUN_CYCLES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          imem_we,
    output logic [IA-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          dmem_we,
    output logic [DA-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic          cpu_hold,
    output logic [IA:0]   loaded_words,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        HALT
    } state_t;

    localparam logic [DA-1:0] DA_LAST = DA'(DATA_MEM_SIZE - 1);
    localparam logic [IA:0]   IA_LAST = (IA + 1)'(INSTR_MEM_SIZE - 1);
    localparam logic [CW-1:0] RC_LAST = CW'(RUN_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    logic          load_ready_n;
    logic          imem_we_n;
    logic [IA-1:0] imem_addr_n;
    logic [31:0]   imem_wdata_n;
    logic          dmem_we_n;
    logic [DA-1:0] dmem_addr_n;
    logic          cpu_hold_n;
    logic [IA:0]   loaded_n;
    logic          done_n;
    logic          error_n;
    logic          accept;

    // Data memory is only ever zero-filled.
    assign dmem_wdata = 32'h0;

    // The ready flag is registered, so a handshake depends only on flops
    // on our side and the source's valid.
    assign accept = load_valid && load_ready;

    // Next-state and next-output logic; every output is the registered
    // copy of these values, so nothing combinational reaches a port.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        load_ready_n = 1'b0;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        dmem_we_n    = 1'b0;
        dmem_addr_n  = dmem_addr;
        cpu_hold_n   = 1'b1;
        loaded_n     = loaded_words;
        done_n       = done;
        error_n      = error;

        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_n     = CLEAR;
                    dmem_we_n   = 1'b1;
                    dmem_addr_n = '0;
                    loaded_n    = '0;
                    done_n      = 1'b0;
                    error_n     = 1'b0;
                end
            end

            CLEAR: begin
                // dmem_addr is the word being zeroed this cycle.
                if (dmem_addr == DA_LAST) begin
                    state_n      = LOAD;
                    load_ready_n = 1'b1;
                end else begin
                    dmem_we_n   = 1'b1;
                    dmem_addr_n = dmem_addr + DA'(1);
                end
            end

            LOAD: begin
                load_ready_n = 1'b1;
                if (accept) begin
                    imem_we_n    = 1'b1;
                    imem_addr_n  = loaded_words[IA-1:0];
                    imem_wdata_n = load_data;
                    loaded_n     = loaded_words + (IA + 1)'(1);
                    if (load_last) begin
                        // The final write lands on the same edge the CPU
                        // sees hold drop, ahead of its first fetch.
                        state_n      = RUN;
                        load_ready_n = 1'b0;
                        cpu_hold_n   = 1'b0;
                        cnt_n        = '0;
                    end else if (loaded_words == IA_LAST) begin
                        // Last slot filled without an end marker: keep
                        // the word but never release the CPU.
                        state_n      = HALT;
                        load_ready_n = 1'b0;
                        error_n      = 1'b1;
                    end
                end
            end

            RUN: begin
                cpu_hold_n = 1'b0;
                if (cnt == RC_LAST) begin
                    state_n    = HALT;
                    cpu_hold_n = 1'b1;
                    done_n     = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            load_ready   <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            cpu_hold     <= 1'b1;
            loaded_words <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            load_ready   <= load_ready_n;
            imem_we      <= imem_we_n;
            imem_addr    <= imem_addr_n;
            imem_wdata   <= imem_wdata_n;
            dmem_we      <= dmem_we_n;
            dmem_addr    <= dmem_addr_n;
            cpu_hold     <= cpu_hold_n;
            loaded_words <= loaded_n;
            done         <= done_n;
            error        <= error_n;
        end
    end

endmodule
